// File: rtl/clock_display_pkg.sv
// Shared constants and types for the multiplexed clock display scanner.
// Segment codes are logical active-high, bit0 = a .. bit6 = g.
package clock_display_pkg;

   localparam logic [6:0] SEG_DIG0  = 7'h3F;
   localparam logic [6:0] SEG_DIG1  = 7'h06;
   localparam logic [6:0] SEG_DIG2  = 7'h5B;
   localparam logic [6:0] SEG_DIG3  = 7'h4F;
   localparam logic [6:0] SEG_DIG4  = 7'h66;
   localparam logic [6:0] SEG_DIG5  = 7'h6D;
   localparam logic [6:0] SEG_DIG6  = 7'h7D;
   localparam logic [6:0] SEG_DIG7  = 7'h07;
   localparam logic [6:0] SEG_DIG8  = 7'h7F;
   localparam logic [6:0] SEG_DIG9  = 7'h6F;
   localparam logic [6:0] SEG_BLANK = 7'h00;

   typedef logic [2:0] digit_idx_t;

   localparam digit_idx_t DIGIT_FIRST = 3'd0;
   localparam digit_idx_t DIGIT_PM    = 3'd0;
   localparam digit_idx_t DIGIT_COLON_MIN  = 3'd2;
   localparam digit_idx_t DIGIT_COLON_HOUR = 3'd4;
   localparam digit_idx_t DIGIT_LAST  = 3'd5;

   typedef enum logic {
      ST_BLANK = 1'b0,
      ST_DRIVE = 1'b1
   } scan_state_t;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to seven-segment decoder, logical active-high output.
// Non-decimal codes (10-15) decode to all segments off.
module bcd_to_seg7
   import clock_display_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      case (bcd)
         4'd0:    seg = SEG_DIG0;
         4'd1:    seg = SEG_DIG1;
         4'd2:    seg = SEG_DIG2;
         4'd3:    seg = SEG_DIG3;
         4'd4:    seg = SEG_DIG4;
         4'd5:    seg = SEG_DIG5;
         4'd6:    seg = SEG_DIG6;
         4'd7:    seg = SEG_DIG7;
         4'd8:    seg = SEG_DIG8;
         4'd9:    seg = SEG_DIG9;
         default: seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/clock_display_scan.sv
// Six-digit multiplexed HH:MM:SS display scanner with frame-level snapshot.
// Optional colon blinking is enabled by defining CLOCK_DISPLAY_BLINK_EN.
//
// state    | meaning
// ST_BLANK | first BLANK_CYC cycles of a dwell, all anodes off
// ST_DRIVE | rest of the dwell, an[idx] on with the shadow digit decoded
module clock_display_scan
   import clock_display_pkg::*;
#(
   parameter int CLK_FREQ   = 100000000,
   parameter int DIGIT_HZ   = 1000,
   parameter int BLANK_CYC  = 2,
   parameter int ACTIVE_LOW = 1
)(
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] sec_units,
   input  logic [3:0] sec_tens,
   input  logic [3:0] min_units,
   input  logic [3:0] min_tens,
   input  logic [3:0] hour_units,
   input  logic [3:0] hour_tens,
   input  logic       is_am,
   output logic [6:0] seg,
   output logic       dp,
   output logic [5:0] an
);

   localparam int DIV = CLK_FREQ / DIGIT_HZ;
   localparam int PW  = $clog2(DIV);
   localparam logic [PW-1:0] PRE_LAST  = PW'(DIV - 1);
   localparam logic [PW-1:0] PRE_BLANK = PW'(BLANK_CYC);
   localparam logic          POL       = (ACTIVE_LOW != 0);

   logic [PW-1:0]   presc;
   digit_idx_t      idx;
   logic            load_pending;
   logic            scan_tick;
   scan_state_t     state;

   logic [5:0][3:0] live_digits;
   logic [5:0][3:0] shadow_digits;
   logic            shadow_am;
   logic [5:0][3:0] view_digits;
   logic            view_am;

   logic [3:0]      cur_digit;
   logic [6:0]      dec_seg;
   logic            colon_on;
   logic [6:0]      seg_next;
   logic            dp_next;
   logic [5:0]      an_next;

   assign live_digits = {hour_tens, hour_units, min_tens, min_units, sec_tens, sec_units};
   assign scan_tick   = (presc == PRE_LAST);
   assign state       = (presc < PRE_BLANK) ? ST_BLANK : ST_DRIVE;

   // The load cycle after reset sees the live inputs so a zero-length blank cannot show stale zeros.
   assign view_digits = load_pending ? live_digits : shadow_digits;
   assign view_am     = load_pending ? is_am : shadow_am;
   assign cur_digit   = view_digits[idx];

   always_ff @(posedge clk) begin
      if (rst) begin
         presc         <= '0;
         idx           <= DIGIT_FIRST;
         load_pending  <= 1'b1;
         shadow_digits <= '0;
         shadow_am     <= 1'b0;
      end else begin
         presc <= scan_tick ? '0 : presc + 1'b1;
         if (scan_tick)
            idx <= (idx == DIGIT_LAST) ? DIGIT_FIRST : idx + 3'd1;
         if (load_pending || (scan_tick && idx == DIGIT_LAST)) begin
            shadow_digits <= live_digits;
            shadow_am     <= is_am;
            load_pending  <= 1'b0;
         end
      end
   end

`ifdef CLOCK_DISPLAY_BLINK_EN
   localparam int HALF = CLK_FREQ / 2;
   localparam int HW   = (HALF > 1) ? $clog2(HALF) : 1;
   localparam logic [HW-1:0] HALF_LAST = HW'(HALF - 1);

   logic [HW-1:0] half_cnt;
   logic          blink_phase;

   always_ff @(posedge clk) begin
      if (rst) begin
         half_cnt    <= HALF_LAST;
         blink_phase <= 1'b0;
      end else if (half_cnt == '0) begin
         half_cnt    <= HALF_LAST;
         blink_phase <= ~blink_phase;
      end else begin
         half_cnt <= half_cnt - 1'b1;
      end
   end

   assign colon_on = ~blink_phase;
`else
   assign colon_on = 1'b1;
`endif

   bcd_to_seg7 u_dec (
      .bcd (cur_digit),
      .seg (dec_seg)
   );

   always_comb begin
      seg_next = SEG_BLANK;
      dp_next  = 1'b0;
      an_next  = '0;
      if (state == ST_DRIVE) begin
         an_next = 6'b000001 << idx;
         if (!(idx == DIGIT_LAST && view_digits[5] == 4'd0))
            seg_next = dec_seg;
         if (idx == DIGIT_PM)
            dp_next = ~view_am;
         else if (idx == DIGIT_COLON_MIN || idx == DIGIT_COLON_HOUR)
            dp_next = colon_on;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         seg <= {7{POL}};
         dp  <= POL;
         an  <= {6{POL}};
      end else begin
         seg <= seg_next ^ {7{POL}};
         dp  <= dp_next ^ POL;
         an  <= an_next ^ {6{POL}};
      end
   end

endmodule
